sync_fifo_ctrl: RTL

- Single-clock FIFO controller that sequences one fifomem instance: owns the write/read pointers, drives the memory's write-enable/address/full inputs, and presents valid/ready handshakes on both sides.
- Sits between a producer and a consumer in the same clock domain.
- fifomem is instantiated outside this block, alongside it, in the parent.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_ptr.sv | 23 ++
 rtl/sync_fifo_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO controller.
// Pointer-width, depth and full/empty compare functions.
package fifo_pkg;

  function automatic int ptr_w(input int asz);
    return asz + 1;
  endfunction

  function automatic int depth(input int asz);
    return 1 << asz;
  endfunction

  // Full: wrap bits differ, address bits match.
  function automatic logic ptr_full(
    input logic [31:0] w,
    input logic [31:0] r,
    input int          asz
  );
    logic [31:0] m;
    m = (32'd1 << asz) - 32'd1;
    return (w[asz] != r[asz]) && ((w & m) == (r & m));
  endfunction

  function automatic logic ptr_empty(
    input logic [31:0] w,
    input logic [31:0] r
  );
    return w == r;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter with synchronous clear.
// Used for both the write and read pointers.
module fifo_ptr #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_inc) r_q <= r_q + W'(1);
  end

  assign o_q = r_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller sequencing an external fifomem.
// Define FIFO_OREG_EN for a registered output stage.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE    = 16,
  parameter int ADDR_SIZE    = 12,
  parameter int AFULL_THRESH = (2**ADDR_SIZE) - 4
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 flush,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATA_SIZE-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic [ADDR_SIZE:0]   count,
  output logic                 almost_full,
  output logic [DATA_SIZE-1:0] mem_wdata,
  output logic [ADDR_SIZE-1:0] mem_waddr,
  output logic [ADDR_SIZE-1:0] mem_raddr,
  output logic                 mem_wclken,
  output logic                 mem_wfull,
  input  logic [DATA_SIZE-1:0] mem_rdata
);

  localparam int PTR_W = ptr_w(ADDR_SIZE);
  localparam logic [PTR_W-1:0] AF_TH = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] w_wptr;
  logic [PTR_W-1:0] w_rptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_rinc;
  logic [PTR_W-1:0] w_cnt_nxt;
  logic [PTR_W-1:0] r_count;
  logic             r_afull;

  assign w_full  = ptr_full(32'(w_wptr), 32'(w_rptr), ADDR_SIZE);
  assign w_empty = ptr_empty(32'(w_wptr), 32'(w_rptr));

  assign wr_ready = !w_full;
  // flush drops any same-cycle write before it reaches memory
  assign w_push   = wr_valid && !w_full && !flush;

  fifo_ptr #(.W(PTR_W)) u_wptr (
    .clk   (wclk),
    .rst   (wrst),
    .i_clr (flush),
    .i_inc (w_push),
    .o_q   (w_wptr)
  );

  fifo_ptr #(.W(PTR_W)) u_rptr (
    .clk   (wclk),
    .rst   (wrst),
    .i_clr (flush),
    .i_inc (w_rinc),
    .o_q   (w_rptr)
  );

`ifdef FIFO_OREG_EN
  logic                 r_ov;
  logic [DATA_SIZE-1:0] r_oreg;
  logic                 w_load;

  assign w_pop  = r_ov && rd_ready && !flush;
  assign w_load = (!r_ov || w_pop) && !w_empty && !flush;
  assign w_rinc = w_load;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst)        r_ov <= 1'b0;
    else if (flush)  r_ov <= 1'b0;
    else if (w_load) r_ov <= 1'b1;
    else if (w_pop)  r_ov <= 1'b0;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst)        r_oreg <= '0;
    else if (w_load) r_oreg <= mem_rdata;
  end

  assign rd_valid = r_ov;
  assign rd_data  = r_oreg;
`else
  assign w_pop    = !w_empty && rd_ready && !flush;
  assign w_rinc   = w_pop;
  assign rd_valid = !w_empty;
  assign rd_data  = mem_rdata;
`endif

  always_comb begin
    w_cnt_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_count + PTR_W'(1);
      2'b01:   w_cnt_nxt = r_count - PTR_W'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_count <= '0;
      r_afull <= 1'b0;
    end else if (flush) begin
      r_count <= '0;
      r_afull <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_afull <= (w_cnt_nxt >= AF_TH);
    end
  end

  assign count       = r_count;
  assign almost_full = r_afull;

  assign mem_wdata  = wr_data;
  assign mem_waddr  = w_wptr[ADDR_SIZE-1:0];
  assign mem_raddr  = w_rptr[ADDR_SIZE-1:0];
  assign mem_wclken = w_push;
  assign mem_wfull  = w_full;

endmodule
